// File: rtl/sdffe_pipe_ift.sv
// Taint-tracked delay line of DEPTH enable flip-flops with synchronous reset,
// a saturating fill counter and a combinational tap readout.
module sdffe_pipe_ift #(
  parameter int               WIDTH        = 2,
  parameter int               DEPTH        = 3,
  parameter int               TAINT_W      = 32,
  parameter logic [WIDTH-1:0] SRST_VALUE   = {WIDTH{1'b0}},
  parameter logic             EN_POLARITY  = 1'b1,
  parameter logic             SRST_OVER_EN = 1'b1,
  localparam int              SEL_W        = $clog2(DEPTH),
  localparam int              FILL_W       = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic [TAINT_W-1:0] CLK_t,
  input  logic               SRST,
  input  logic [TAINT_W-1:0] SRST_t,
  input  logic               EN,
  input  logic [TAINT_W-1:0] EN_t,
  input  logic [WIDTH-1:0]   D,
  input  logic [TAINT_W-1:0] D_t,
  input  logic [SEL_W-1:0]   TAP_SEL,
  input  logic [TAINT_W-1:0] TAP_SEL_t,
  output logic [WIDTH-1:0]   Q,
  output logic [TAINT_W-1:0] Q_t,
  output logic [WIDTH-1:0]   TAP_Q,
  output logic [TAINT_W-1:0] TAP_Q_t,
  output logic [FILL_W-1:0]  FILL,
  output logic               FULL,
  output logic [TAINT_W-1:0] FULL_t
);

  // Taint state powers up clean; data and fill stay unknown until reset.
  logic [WIDTH-1:0]   data_q [DEPTH];
  logic [WIDTH-1:0]   data_d [DEPTH];
  logic [TAINT_W-1:0] taint_q [DEPTH] = '{default: '0};
  logic [TAINT_W-1:0] taint_d [DEPTH];
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;
  logic [TAINT_W-1:0] full_t_q = '0;
  logic [TAINT_W-1:0] full_t_d;

  logic en_act;
  logic rst_eff;
  logic unused_clk_t;

  assign unused_clk_t = ^CLK_t;
  assign en_act  = (EN == EN_POLARITY);
  assign rst_eff = SRST_OVER_EN ? SRST : (SRST & en_act);

  always_comb begin
    data_d   = data_q;
    taint_d  = taint_q;
    fill_d   = fill_q;
    full_t_d = full_t_q;
    if (rst_eff) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i]  = SRST_VALUE;
        taint_d[i] = SRST_t;
      end
      fill_d   = '0;
      full_t_d = SRST_t;
    end else if (en_act) begin
      // An unknown input word carries no taint into stage 0.
      data_d[0]  = D;
      taint_d[0] = $isunknown(D) ? '0 : (D_t | EN_t);
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        taint_d[i] = taint_q[i-1] | EN_t;
      end
      if (fill_q < FILL_W'(DEPTH)) begin
        fill_d   = fill_q + FILL_W'(1);
        full_t_d = full_t_q | EN_t;
      end
    end
  end

  always_ff @(posedge CLK) begin
    data_q   <= data_d;
    taint_q  <= taint_d;
    fill_q   <= fill_d;
    full_t_q <= full_t_d;
  end

  // Readout: last stage, fill status and the selected tap.
  assign Q      = data_q[DEPTH-1];
  assign Q_t    = taint_q[DEPTH-1];
  assign FILL   = fill_q;
  assign FULL   = (fill_q == FILL_W'(DEPTH));
  assign FULL_t = full_t_q;

  always_comb begin
    TAP_Q   = '0;
    TAP_Q_t = TAP_SEL_t;
    if ({1'b0, TAP_SEL} < (SEL_W + 1)'(DEPTH)) begin
      TAP_Q   = data_q[TAP_SEL];
      TAP_Q_t = taint_q[TAP_SEL] | TAP_SEL_t;
    end
  end

endmodule
